uart_image_buffer: RTL and testbench
====================================

# uart_image_buffer

Parametrised UART receive front end with a double-buffered (ping-pong) image store. It deserialises pixels from a serial line and writes them into one bank while the neural-network core reads a completed image from the other. It replaces the single-bank loader ahead of the input layer. It adds configurable baud, pixel width and image size, stop-bit checking, glitch rejection, bank release and overflow reporting.

## Interface
- CLKS_PER_BIT, 4: clock cycles per serial bit, ≥ 4 and even.
- DATA_BITS, 8: bits per pixel, LSB first on the line.
- IMG_PIXELS, 784: pixels per image (per bank).
- ADDR_W, 16: read-address and counter width; 2^ADDR_W > IMG_PIXELS.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset. One clock domain, `clk`.
- rx  in  1  serial input, idle high, asynchronous to clk.
- read_request  in  1  read strobe, sampled every cycle.
- addr  in  ADDR_W  pixel index for reads.
- release_bank  in  1  one-cycle pulse: consumer is done with the current read bank.
- data_out  out  DATA_BITS  registered read data.
- valid_data  out  1  data_out valid this cycle.
- image_written  out  1  level: at least one full bank is readable.
- rd_bank  out  1  index of the bank currently presented for reads.
- pixel_count  out  ADDR_W  pixels written into the current write bank.
- frame_error  out  1  one-cycle pulse on a bad stop bit.
- overflow  out  1  sticky: a pixel was dropped because both banks were full.

## Operation
- rx passes through a 2-flop synchronizer. All receiver logic uses the synchronized value rxs.
- Receiver FSM:
  - IDLE: a falling edge on rxs moves to START and clears the bit timer.
  - START: after CLKS_PER_BIT/2 cycles, sample rxs.
    - If low, go to DATA.
    - If high, the start was a glitch: return to IDLE with no other effect.
  - DATA: sample every CLKS_PER_BIT cycles, at mid-bit, and shift in LSB first. After DATA_BITS samples, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles, then return to IDLE.
    - Sample = 1: the pixel is accepted (internal byte_valid for one cycle).
    - Sample = 0: frame_error pulses and the pixel is discarded.
- Banks:
  - Two IMG_PIXELS × DATA_BITS memories with full flags full[0] and full[1]. Write bank is wb.
  - An accepted pixel is written to mem[wb][pixel_count], then pixel_count increments.
  - When the write makes pixel_count reach IMG_PIXELS: full[wb] is set, pixel_count goes to 0, and wb toggles.
  - If the new wb is already full, the writer is stalled.
  - While stalled (full[wb]=1), accepted pixels are dropped and overflow is set. overflow stays set until reset.
- Read side:
  - image_written = full[0] | full[1].
  - rd_bank is the oldest full bank. With one full bank it is that bank. With both full it stays on the bank filled first.
  - release_bank while image_written clears full[rd_bank], and rd_bank moves to the other bank.
  - release_bank while !image_written is ignored.
- Reads:
  - When read_request & image_written & addr < IMG_PIXELS: data_out <= mem[rd_bank][addr] and valid_data <= 1.
  - Otherwise valid_data <= 0 and data_out holds its value.
- Simultaneous events:
  - release_bank and bank completion in the same cycle: release applies to the old rd_bank. The completed bank becomes readable and becomes rd_bank if the other bank is now empty.
  - A pixel accepted in the same cycle as a release that frees wb is written, not dropped.
  - A read in the same cycle as release_bank uses the pre-release rd_bank.

## Timing
- Reset values: data_out 0, valid_data 0, image_written 0, rd_bank 0, pixel_count 0, frame_error 0, overflow 0.
- Reset internals: FSM IDLE, wb 0, full flags 0. Memory contents are not reset.
- Reset asserted mid-frame or mid-image aborts everything. The partial image is lost and the first frame after release starts at pixel 0 of bank 0.
- rx edge to FSM leaving IDLE: 3 clk cycles (2 synchronizer stages + edge detect).
- Pixel write, pixel_count increment and frame_error all occur on the clock edge that takes the stop sample.
- image_written rises the cycle after the last pixel's write edge.
- Read latency: 1 cycle from read_request/addr to data_out/valid_data. Back-to-back reads at 1 per cycle are supported.
- rd_bank and image_written update the cycle after release_bank.

## Test plan
- Single pixel: IMG_PIXELS=4, CLKS_PER_BIT=4, send 0xA5 with a valid stop bit -> pixel_count=1, no frame_error, image_written=0.
- Full image: IMG_PIXELS=784, send pixels i%128 for i=0..783, then read addr 0..783 with read_request=1 -> image_written=1, rd_bank=0, data_out=addr%128 one cycle after each addr, valid_data=1 throughout; addr=784 -> valid_data=0.
- Framing error: send 0x3C with stop bit 0 -> frame_error pulses once, pixel_count unchanged. A following valid 0x3C is written at index 0.
- Glitch: a 1-cycle low pulse on rx -> FSM returns to IDLE, no pixel written, no frame_error.
- Ping-pong and overflow (IMG_PIXELS=4):
  - Send 8 pixels -> both banks full, rd_bank=0.
  - 9th pixel -> overflow=1, pixel dropped.
  - release_bank -> rd_bank=1.
  - 10th pixel -> written to bank 0 index 0.
- Reset mid-frame: assert reset_n=0 during DATA of pixel 3 -> all outputs at reset values. A new image then starts at bank 0, index 0.

Source files
------------

// File: rtl/uart_image_buffer.sv
// UART pixel receiver feeding a ping-pong pair of image banks: one bank fills
// from the serial line while the consumer reads a completed image from the other.
module uart_image_buffer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int IMG_PIXELS   = 784,
    parameter int ADDR_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 read_request,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 release_bank,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_data,
    output logic                 image_written,
    output logic                 rd_bank,
    output logic [ADDR_W-1:0]    pixel_count,
    output logic                 frame_error,
    output logic                 overflow
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int IDX_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;

    localparam logic [TMR_W-1:0]  HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0]  BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [ADDR_W-1:0] IMG_N     = ADDR_W'(IMG_PIXELS);
    localparam logic [ADDR_W-1:0] IMG_LAST  = ADDR_W'(IMG_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    rx_state_t              r_state;
    logic [TMR_W-1:0]       r_timer;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_rx_meta;
    logic                   r_rxs;
    logic                   r_rxs_d;
    logic                   r_frame_error;

    logic [DATA_BITS-1:0]   r_mem [2][IMG_PIXELS];
    logic [1:0]             r_full;
    logic                   r_wb;
    logic                   r_rd_bank;
    logic [ADDR_W-1:0]      r_pixel_count;
    logic                   r_overflow;
    logic [DATA_BITS-1:0]   r_data_out;
    logic                   r_valid_data;

    logic                   w_rx_fall;
    logic                   w_byte_valid;
    logic                   w_release;
    logic                   w_wb_free;
    logic                   w_write;
    logic                   w_drop;
    logic                   w_complete;
    logic [1:0]             w_full_nxt;
    logic                   w_rd_nxt;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
        end
    end

    assign w_rx_fall    = r_rxs_d & ~r_rxs;
    assign w_byte_valid = (r_state == S_STOP) && (r_timer == BIT_LAST) && r_rxs;

    // Receiver FSM: start qualification, mid-bit data sampling, stop check
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_timer       <= {TMR_W{1'b0}};
            r_bit_cnt     <= {BIT_W{1'b0}};
            r_shift       <= {DATA_BITS{1'b0}};
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fall) begin
                        r_state <= S_START;
                        r_timer <= {TMR_W{1'b0}};
                    end
                end
                S_START: begin
                    if (r_timer == HALF_LAST) begin
                        r_timer   <= {TMR_W{1'b0}};
                        r_bit_cnt <= {BIT_W{1'b0}};
                        r_state   <= r_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_timer == BIT_LAST) begin
                        r_timer <= {TMR_W{1'b0}};
                        r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == DATA_LAST) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_timer == BIT_LAST) begin
                        r_timer       <= {TMR_W{1'b0}};
                        r_state       <= S_IDLE;
                        r_frame_error <= ~r_rxs;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bank bookkeeping: a release in the same cycle frees the write bank before the stall test
    always_comb begin
        w_release  = release_bank & (r_full[0] | r_full[1]);
        w_wb_free  = ~r_full[r_wb] | (w_release & (r_rd_bank == r_wb));
        w_write    = w_byte_valid & w_wb_free;
        w_drop     = w_byte_valid & ~w_wb_free;
        w_complete = w_write & (r_pixel_count == IMG_LAST);
        w_full_nxt[0] = (r_full[0] & ~(w_release & ~r_rd_bank)) | (w_complete & ~r_wb);
        w_full_nxt[1] = (r_full[1] & ~(w_release &  r_rd_bank)) | (w_complete &  r_wb);
        case (w_full_nxt)
            2'b01:   w_rd_nxt = 1'b0;
            2'b10:   w_rd_nxt = 1'b1;
            default: w_rd_nxt = r_rd_bank ^ w_release;
        endcase
    end

    // Write-side state: pixel counter, write bank, full flags, read bank, overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel_count <= {ADDR_W{1'b0}};
            r_wb          <= 1'b0;
            r_full        <= 2'b00;
            r_rd_bank     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_full     <= w_full_nxt;
            r_rd_bank  <= w_rd_nxt;
            r_overflow <= r_overflow | w_drop;
            if (w_complete) begin
                r_pixel_count <= {ADDR_W{1'b0}};
                r_wb          <= ~r_wb;
            end else if (w_write) begin
                r_pixel_count <= r_pixel_count + ADDR_W'(1);
            end
        end
    end

    // Image storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wb][r_pixel_count[IDX_W-1:0]] <= r_shift;
        end
    end

    // Registered read port using the pre-release read bank
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out   <= {DATA_BITS{1'b0}};
            r_valid_data <= 1'b0;
        end else if (read_request && (r_full != 2'b00) && (addr < IMG_N)) begin
            r_data_out   <= r_mem[r_rd_bank][addr[IDX_W-1:0]];
            r_valid_data <= 1'b1;
        end else begin
            r_valid_data <= 1'b0;
        end
    end

    assign data_out      = r_data_out;
    assign valid_data    = r_valid_data;
    assign image_written = r_full[0] | r_full[1];
    assign rd_bank       = r_rd_bank;
    assign pixel_count   = r_pixel_count;
    assign frame_error   = r_frame_error;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_uart_image_buffer.sv
// Bench for uart_image_buffer: a 4-pixel instance exercises ping-pong, overflow and
// reset paths against a queue-based bank model; a 784-pixel instance takes a full image.
module tb_uart_image_buffer;

    localparam int CPB = 4;
    localparam int SP  = 4;
    localparam int LP  = 784;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_s, rx_s, rr_s, rel_s;
    logic [15:0] addr_s;
    logic [7:0]  dout_s;
    logic        dv_s, iw_s, rdb_s, fe_s, ovf_s;
    logic [15:0] pc_s;

    logic        rst_n_l, rx_l, rr_l, rel_l;
    logic [15:0] addr_l;
    logic [7:0]  dout_l;
    logic        dv_l, iw_l, rdb_l, fe_l, ovf_l;
    logic [15:0] pc_l;

    uart_image_buffer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .IMG_PIXELS(SP), .ADDR_W(16)) dut_s (
        .clk(clk), .reset_n(rst_n_s), .rx(rx_s), .read_request(rr_s), .addr(addr_s),
        .release_bank(rel_s), .data_out(dout_s), .valid_data(dv_s), .image_written(iw_s),
        .rd_bank(rdb_s), .pixel_count(pc_s), .frame_error(fe_s), .overflow(ovf_s)
    );

    uart_image_buffer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .IMG_PIXELS(LP), .ADDR_W(16)) dut_l (
        .clk(clk), .reset_n(rst_n_l), .rx(rx_l), .read_request(rr_l), .addr(addr_l),
        .release_bank(rel_l), .data_out(dout_l), .valid_data(dv_l), .image_written(iw_l),
        .rd_bank(rdb_l), .pixel_count(pc_l), .frame_error(fe_l), .overflow(ovf_l)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cnt_s = 0;
    int fe_cnt_l = 0;

    // Count frame_error pulses seen on each instance
    always @(negedge clk) begin
        if (fe_s === 1'b1) fe_cnt_s++;
        if (fe_l === 1'b1) fe_cnt_l++;
    end

    // Reference model of the small instance: banks in fill order kept in a queue
    logic [7:0] m_mem [2][SP];
    int         m_q[$];
    int         m_wb, m_cnt, m_rd_idle;
    bit         m_ovf;

    task automatic m_reset();
        m_q.delete();
        m_wb = 0; m_cnt = 0; m_rd_idle = 0; m_ovf = 1'b0;
    endtask

    task automatic m_pixel(input logic [7:0] v);
        if (m_q.size() == 2) begin
            m_ovf = 1'b1;
        end else begin
            m_mem[m_wb][m_cnt] = v;
            m_cnt++;
            if (m_cnt == SP) begin
                m_q.push_back(m_wb);
                m_cnt = 0;
                m_wb  = 1 - m_wb;
            end
        end
    endtask

    task automatic m_release();
        if (m_q.size() > 0) begin
            m_rd_idle = 1 - m_q[0];
            void'(m_q.pop_front());
        end
    endtask

    function automatic int m_rd();
        return (m_q.size() > 0) ? m_q[0] : m_rd_idle;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state_s(input string tag);
        chk({tag, "_count"}, 32'(pc_s), 32'(m_cnt));
        chk({tag, "_written"}, 32'(iw_s), 32'(m_q.size() > 0));
        chk({tag, "_rd_bank"}, 32'(rdb_s), 32'(m_rd()));
        chk({tag, "_overflow"}, 32'(ovf_s), 32'(m_ovf));
    endtask

    task automatic check_reset_s(input string tag);
        chk({tag, "_dout"}, 32'(dout_s), 32'd0);
        chk({tag, "_valid"}, 32'(dv_s), 32'd0);
        chk({tag, "_written"}, 32'(iw_s), 32'd0);
        chk({tag, "_rd_bank"}, 32'(rdb_s), 32'd0);
        chk({tag, "_count"}, 32'(pc_s), 32'd0);
        chk({tag, "_ferr"}, 32'(fe_s), 32'd0);
        chk({tag, "_overflow"}, 32'(ovf_s), 32'd0);
    endtask

    task automatic drive_rx(input bit big, input logic v);
        if (big) rx_l = v;
        else     rx_s = v;
    endtask

    // One frame: start bit, LSB-first data, stop bit, then one idle bit
    task automatic send(input bit big, input logic [7:0] v, input logic stop);
        logic [9:0] fr;
        fr = {stop, v, 1'b0};
        for (int b = 0; b < 10; b++) begin
            drive_rx(big, fr[b]);
            repeat (CPB) @(negedge clk);
        end
        drive_rx(big, 1'b1);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic spx(input logic [7:0] v, input string tag);
        int fe0;
        fe0 = fe_cnt_s;
        send(1'b0, v, 1'b1);
        m_pixel(v);
        chk({tag, "_no_ferr"}, 32'(fe_cnt_s - fe0), 32'd0);
        check_state_s(tag);
    endtask

    task automatic spx_rand(input int n, input string tag);
        for (int k = 0; k < n; k++) spx(8'($urandom_range(255, 0)), tag);
    endtask

    // Back-to-back reads of the whole current read bank, then one out-of-range read
    task automatic read_bank_s(input string tag);
        rr_s = 1'b1;
        for (int a = 0; a <= SP; a++) begin
            addr_s = 16'(a);
            @(negedge clk);
            if (a < SP) begin
                chk({tag, "_valid"}, 32'(dv_s), 32'd1);
                chk({tag, "_data"}, 32'(dout_s), 32'(m_mem[m_rd()][a]));
            end else begin
                chk({tag, "_oob_valid"}, 32'(dv_s), 32'd0);
                chk({tag, "_oob_hold"}, 32'(dout_s), 32'(m_mem[m_rd()][SP-1]));
            end
        end
        rr_s = 1'b0;
    endtask

    task automatic release_s(input string tag);
        rel_s = 1'b1;
        @(negedge clk);
        rel_s = 1'b0;
        m_release();
        @(negedge clk);
        check_state_s(tag);
    endtask

    task automatic pulse_reset_s();
        rst_n_s = 1'b0;
        @(negedge clk);
        rst_n_s = 1'b1;
        m_reset();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int fe0;
        logic [7:0] v;
        rst_n_s = 1'b0; rx_s = 1'b1; rr_s = 1'b0; rel_s = 1'b0; addr_s = 16'd0;
        rst_n_l = 1'b0; rx_l = 1'b1; rr_l = 1'b0; rel_l = 1'b0; addr_l = 16'd0;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset_s("reset");
        chk("reset_l_written", 32'(iw_l), 32'd0);
        chk("reset_l_count", 32'(pc_l), 32'd0);
        rst_n_s = 1'b1;
        rst_n_l = 1'b1;
        repeat (2) @(negedge clk);

        // Release and read with no full bank are ignored
        release_s("idle_release");
        rr_s = 1'b1; addr_s = 16'd0;
        @(negedge clk);
        chk("idle_read_valid", 32'(dv_s), 32'd0);
        rr_s = 1'b0;

        spx(8'hA5, "single");

        // Bad stop bit, then a good copy of the same byte
        pulse_reset_s();
        fe0 = fe_cnt_s;
        send(1'b0, 8'h3C, 1'b0);
        chk("ferr_pulses", 32'(fe_cnt_s - fe0), 32'd1);
        check_state_s("ferr");
        spx(8'h3C, "after_ferr");

        // One-cycle low glitch on rx
        fe0 = fe_cnt_s;
        rx_s = 1'b0;
        @(negedge clk);
        rx_s = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_no_ferr", 32'(fe_cnt_s - fe0), 32'd0);
        check_state_s("glitch");

        // Fill both banks, overflow, release, refill
        spx_rand(3, "fill0");
        read_bank_s("bank0");
        spx_rand(4, "fill1");
        spx_rand(1, "ovf");
        read_bank_s("both_full");
        release_s("rel1");
        read_bank_s("bank1");
        spx(8'($urandom_range(255, 0)), "px10");
        release_s("rel2");
        spx_rand(3, "refill0");
        read_bank_s("bank0_again");

        // Reset in the data phase of the third pixel of an image
        spx_rand(2, "pre_rst");
        v = 8'($urandom_range(255, 0));
        rx_s = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            rx_s = v[b];
            repeat (CPB) @(negedge clk);
        end
        rst_n_s = 1'b0;
        @(negedge clk);
        rx_s = 1'b1;
        @(negedge clk);
        check_reset_s("mid_reset");
        rst_n_s = 1'b1;
        m_reset();
        repeat (8) @(negedge clk);
        check_state_s("post_reset");
        spx_rand(4, "post_rst_fill");
        read_bank_s("post_rst_bank0");

        // Full-size image on the large instance
        for (int i = 0; i < LP; i++) send(1'b1, 8'(i % 128), 1'b1);
        chk("big_written", 32'(iw_l), 32'd1);
        chk("big_rd_bank", 32'(rdb_l), 32'd0);
        chk("big_count", 32'(pc_l), 32'd0);
        chk("big_no_ferr", 32'(fe_cnt_l), 32'd0);
        chk("big_overflow", 32'(ovf_l), 32'd0);
        rr_l = 1'b1;
        for (int a = 0; a <= LP; a++) begin
            addr_l = 16'(a);
            @(negedge clk);
            if (a < LP) begin
                chk("big_valid", 32'(dv_l), 32'd1);
                chk("big_data", 32'(dout_l), 32'(a % 128));
            end else begin
                chk("big_oob_valid", 32'(dv_l), 32'd0);
                chk("big_oob_hold", 32'(dout_l), 32'((LP - 1) % 128));
            end
        end
        rr_l = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
